// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / pulse meter pair.
// Holds the meter FSM state type and the default counter widths so that the
// generator's interval planning and the meter agree on the measurable range.
package pulse_pkg;

  // Default width of cycle counters and measurement outputs.
  localparam int CNT_W_DEF  = 16;
  // Default width of the published-measurement counter.
  localparam int PCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Edge detector for the pulse meter input, with an optional 2-cycle agreement
// glitch filter (enabled by defining PULSE_METER_GLITCH_EN).
// Latency: rise/fall are combinational off the raw input, or 2 cycles later when filtered.
// Ports: clk, reset (sync, active-high), pulse_in (raw level) -> rise, fall (1-cycle strobes).
module pulse_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  logic lvl;
  logic pulse_d;

`ifdef PULSE_METER_GLITCH_EN
  logic samp;
  logic filt;

  // The filtered level only moves once the raw input has shown the same new
  // value on two consecutive cycles, so a single-cycle glitch never gets through.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= 1'b0;
      filt <= 1'b0;
    end else begin
      samp <= pulse_in;
      if (pulse_in == samp) filt <= pulse_in;
    end
  end

  assign lvl = filt;
`else
  assign lvl = pulse_in;
`endif

  // Tracks the level every cycle regardless of enable, so a level that is
  // already high when measurement starts is never mistaken for a rise.
  always_ff @(posedge clk) begin
    if (reset) pulse_d <= 1'b0;
    else       pulse_d <= lvl;
  end

  assign rise = lvl & ~pulse_d;
  assign fall = ~lvl & pulse_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures high width and rise-to-rise period of a pulse train in clk cycles and
// publishes one {width, period} per completed period over valid/ready.
// Optional input glitch filter: define PULSE_METER_GLITCH_EN (adds 2 cycles latency).
// Ports: clk, reset (sync, active-high), enable, pulse_in, clr_flags, meas_ready in;
//        meas_width, meas_period, meas_valid, overrun, timeout, pulse_count out.
module pulse_meter
  import pulse_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pulse_in,
  input  logic              clr_flags,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_period,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic              overrun,
  output logic              timeout,
  output logic [PCNT_W-1:0] pulse_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PCNT_W-1:0] PCNT_ONE = {{(PCNT_W-1){1'b0}}, 1'b1};

  meter_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_r;
  logic             rise;
  logic             fall;
  logic             publish;
  logic             to_set;
  logic             ovr_set;

  pulse_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Saturation takes priority over any edge in the same cycle: a period that
  // ran the counter out is never published.
  always_comb begin
    to_set  = 1'b0;
    publish = 1'b0;
    if (enable && (state != IDLE)) begin
      if (cnt == CNT_MAX)                to_set  = 1'b1;
      else if ((state == LOW) && rise)   publish = 1'b1;
    end
  end

  // A publish that finds the output still occupied and not being taken is dropped.
  assign ovr_set = publish & meas_valid & ~meas_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      width_r     <= '0;
      meas_width  <= '0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      pulse_count <= '0;
    end else begin
      // Measurement FSM
      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        width_r <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end
          end
          HIGH: begin
            if (to_set) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                width_r <= cnt;
                state   <= LOW;
              end
            end
          end
          LOW: begin
            if (to_set) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end

      // Output register: holds data stable until accepted
      if (publish && (!meas_valid || meas_ready)) begin
        meas_width  <= width_r;
        meas_period <= cnt;
        meas_valid  <= 1'b1;
        pulse_count <= pulse_count + PCNT_ONE;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      // Sticky flags: a set in the same cycle as a clear wins
      overrun <= ovr_set | (overrun & ~clr_flags);
      timeout <= to_set  | (timeout & ~clr_flags);
    end
  end

endmodule
